// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM states, forward-select codes and default register address width.
package pipe_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// pipe_fwd_unit: combinational ALU operand forward select; EX/MEM beats MEM/WB, r0 never forwards.
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] ex_rs,
  input  logic [W-1:0] ex_rt,
  input  logic         mem_reg_w,
  input  logic [W-1:0] mem_wr_reg,
  input  logic         wb_reg_w,
  input  logic [W-1:0] wb_wr_reg,
  output logic [1:0]   fwd_a,
  output logic [1:0]   fwd_b
);
  function automatic logic [1:0] sel(input logic [W-1:0] r, input logic mw, input logic [W-1:0] md,
                                     input logic ww, input logic [W-1:0] wd);
    return (mw && md != '0 && md == r) ? FWD_EXMEM :
           (ww && wd != '0 && wd == r) ? FWD_MEMWB : FWD_RF;
  endfunction
  assign fwd_a = sel(ex_rs, mem_reg_w, mem_wr_reg, wb_reg_w, wb_wr_reg);
  assign fwd_b = sel(ex_rt, mem_reg_w, mem_wr_reg, wb_reg_w, wb_wr_reg);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline hazard sequencer (RAW stall/forward, branch flush, dmem freeze + watchdog).
// PIPE_HAZARD_FWD_EN enables forwarding; without it every RAW match stalls until the writer leaves WB.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_reg_w,
  input  logic                  ex_mem_r,
  input  logic [REG_ADDR_W-1:0] ex_wr_reg,
  input  logic                  mem_reg_w,
  input  logic                  mem_mem_r,
  input  logic                  mem_mem_w,
  input  logic [REG_ADDR_W-1:0] mem_wr_reg,
  input  logic                  mem_branch_taken,
  input  logic                  wb_reg_w,
  input  logic [REG_ADDR_W-1:0] wb_wr_reg,
  input  logic                  dmem_ready,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_wait,
  output logic                  mem_err
);
  import pipe_pkg::*;
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic mem_acc, frz, load_use, stall;
  function automatic logic id_hit(input logic [REG_ADDR_W-1:0] w, input logic [REG_ADDR_W-1:0] rs,
                                  input logic [REG_ADDR_W-1:0] rt, input logic use_rt);
    return w != '0 && (w == rs || (use_rt && w == rt));
  endfunction
  assign mem_acc  = mem_mem_r | mem_mem_w;
  assign frz      = (mem_acc & ~dmem_ready) | (state == ERR);
  assign load_use = ex_mem_r & id_hit(ex_wr_reg, id_rs, id_rt, id_uses_rt);
`ifdef PIPE_HAZARD_FWD_EN
  logic unused;
  assign unused = ex_reg_w;
  assign stall  = load_use;
  pipe_fwd_unit #(.W(REG_ADDR_W)) u_fwd (
    .ex_rs(ex_rs),
    .ex_rt(ex_rt),
    .mem_reg_w(mem_reg_w),
    .mem_wr_reg(mem_wr_reg),
    .wb_reg_w(wb_reg_w),
    .wb_wr_reg(wb_wr_reg),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b)
  );
`else
  logic unused;
  assign unused = ^{ex_rs, ex_rt};
  assign stall  = load_use
                | (ex_reg_w  & id_hit(ex_wr_reg,  id_rs, id_rt, id_uses_rt))
                | (mem_reg_w & id_hit(mem_wr_reg, id_rs, id_rt, id_uses_rt))
                | (wb_reg_w  & id_hit(wb_wr_reg,  id_rs, id_rt, id_uses_rt));
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif
  // a taken branch overrides any stall; a freeze overrides both, deferring the flush to release
  assign pc_we       = ~frz & (mem_branch_taken | ~stall);
  assign ifid_we     = ~frz & (mem_branch_taken | ~stall);
  assign ifid_flush  = ~frz & mem_branch_taken;
  assign idex_flush  = ~frz & (mem_branch_taken | stall);
  assign exmem_flush = ~frz & mem_branch_taken;
  assign exmem_we    = ~frz;
  assign memwb_we    = ~frz;
  assign mem_wait    = state == MEM_WAIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN:
          if (mem_acc & ~dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= CW'(1);
          end
        MEM_WAIT:
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (MEM_TIMEOUT > 0 && wait_cnt == CW'(MEM_TIMEOUT)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [6:0] DEF = 7'b1100011;
  localparam logic [6:0] STL = 7'b0001011;
  localparam logic [6:0] FLS = 7'b1111111;
  localparam logic [6:0] FRZ = 7'b0000000;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic id_uses_rt, ex_reg_w, ex_mem_r, mem_reg_w, mem_mem_r, mem_mem_w, mem_branch_taken, wb_reg_w, dmem_ready;
  logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, exmem_we, memwb_we, mem_wait, mem_err;
  logic [1:0] fwd_a, fwd_b;
  typedef struct {
    string n;
    logic [12:0] v;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r), .ex_wr_reg(ex_wr_reg),
    .mem_reg_w(mem_reg_w), .mem_mem_r(mem_mem_r), .mem_mem_w(mem_mem_w), .mem_wr_reg(mem_wr_reg),
    .mem_branch_taken(mem_branch_taken), .wb_reg_w(wb_reg_w), .wb_wr_reg(wb_wr_reg),
    .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_wait(mem_wait), .mem_err(mem_err)
  );
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [12:0] got;
      e = q.pop_front();
      got = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, exmem_we, memwb_we, fwd_a, fwd_b, mem_wait, mem_err};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.n, got, e.v);
      end
    end
  end
  task automatic clr();
    {id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg} = '0;
    {id_uses_rt, ex_reg_w, ex_mem_r, mem_reg_w, mem_mem_r, mem_mem_w, mem_branch_taken, wb_reg_w} = '0;
    dmem_ready = 1'b1;
  endtask
  task automatic cyc(input string n, input bit c, input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic mw, input logic me);
    exp_t e;
    e.n = n;
    e.v = {ctl, fa, fb, mw, me};
    if (c) q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    cyc("rst0", 0, DEF, 2'b00, 2'b00, 0, 0);
    cyc("rst1", 0, DEF, 2'b00, 2'b00, 0, 0);
    rst = 1'b0;
    cyc("reset", 1, DEF, 2'b00, 2'b00, 0, 0);
    // load-use on rs, then on rt, then r0 never matches
    ex_mem_r = 1; ex_wr_reg = 8; id_rs = 8;
    cyc("lu_rs", 1, STL, 2'b00, 2'b00, 0, 0);
    clr();
    cyc("lu_rel", 1, DEF, 2'b00, 2'b00, 0, 0);
    ex_mem_r = 1; ex_wr_reg = 8; id_rt = 8; id_uses_rt = 1;
    cyc("lu_rt", 1, STL, 2'b00, 2'b00, 0, 0);
    id_uses_rt = 0;
    cyc("lu_rt_unused", 1, DEF, 2'b00, 2'b00, 0, 0);
    clr(); ex_mem_r = 1;
    cyc("lu_r0", 1, DEF, 2'b00, 2'b00, 0, 0);
    // forwarding priority (ID sources are r0, so no stall in either build)
    clr(); mem_reg_w = 1; mem_wr_reg = 3; wb_reg_w = 1; wb_wr_reg = 3; ex_rs = 3;
    cyc("fwd_exmem", 1, DEF, FWD ? 2'b10 : 2'b00, 2'b00, 0, 0);
    mem_reg_w = 0;
    cyc("fwd_memwb", 1, DEF, FWD ? 2'b01 : 2'b00, 2'b00, 0, 0);
    mem_reg_w = 1; mem_wr_reg = 0; wb_wr_reg = 0; ex_rs = 0;
    cyc("fwd_r0", 1, DEF, 2'b00, 2'b00, 0, 0);
    clr(); wb_reg_w = 1; wb_wr_reg = 7; ex_rt = 7; mem_reg_w = 1; mem_wr_reg = 6;
    cyc("fwd_b", 1, DEF, 2'b00, FWD ? 2'b01 : 2'b00, 0, 0);
    // branch overrides load-use
    clr(); mem_branch_taken = 1; ex_mem_r = 1; ex_wr_reg = 8; id_rs = 8;
    cyc("br_vs_lu", 1, FLS, 2'b00, 2'b00, 0, 0);
    // writer of r5 walking EX -> MEM -> WB while ID reads r5
    clr(); id_rs = 5; ex_reg_w = 1; ex_wr_reg = 5;
    cyc("raw_ex", 1, FWD ? DEF : STL, 2'b00, 2'b00, 0, 0);
    clr(); id_rs = 5; mem_reg_w = 1; mem_wr_reg = 5;
    cyc("raw_mem", 1, FWD ? DEF : STL, 2'b00, 2'b00, 0, 0);
    clr(); id_rs = 5; wb_reg_w = 1; wb_wr_reg = 5;
    cyc("raw_wb", 1, FWD ? DEF : STL, 2'b00, 2'b00, 0, 0);
    clr(); id_rs = 5;
    cyc("raw_rel", 1, DEF, 2'b00, 2'b00, 0, 0);
    // 4-cycle memory wait then ready
    clr(); mem_mem_r = 1; dmem_ready = 0;
    cyc("mw0", 1, FRZ, 2'b00, 2'b00, 0, 0);
    for (int i = 1; i < 4; i++) cyc("mw_wait", 1, FRZ, 2'b00, 2'b00, 1, 0);
    dmem_ready = 1;
    cyc("mw_ready", 1, DEF, 2'b00, 2'b00, 1, 0);
    clr();
    cyc("mw_run", 1, DEF, 2'b00, 2'b00, 0, 0);
    // branch during freeze is applied on the release cycle
    mem_mem_r = 1; dmem_ready = 0; mem_branch_taken = 1;
    cyc("br_frz", 1, FRZ, 2'b00, 2'b00, 0, 0);
    dmem_ready = 1;
    cyc("br_release", 1, FLS, 2'b00, 2'b00, 1, 0);
    clr();
    cyc("br_after", 1, DEF, 2'b00, 2'b00, 0, 0);
    // watchdog timeout, sticky error, reset recovery
    mem_mem_w = 1; dmem_ready = 0;
    cyc("to_start", 1, FRZ, 2'b00, 2'b00, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("to_wait", 1, FRZ, 2'b00, 2'b00, 1, 0);
    cyc("to_err", 1, FRZ, 2'b00, 2'b00, 0, 1);
    clr();
    cyc("err_sticky", 1, FRZ, 2'b00, 2'b00, 0, 1);
    mem_branch_taken = 1;
    cyc("err_no_flush", 1, FRZ, 2'b00, 2'b00, 0, 1);
    clr(); rst = 1;
    cyc("err_rst", 0, FRZ, 2'b00, 2'b00, 0, 1);
    rst = 0;
    cyc("err_cleared", 1, DEF, 2'b00, 2'b00, 0, 0);
    // reset mid-wait
    mem_mem_r = 1; dmem_ready = 0;
    cyc("mid0", 1, FRZ, 2'b00, 2'b00, 0, 0);
    cyc("mid1", 1, FRZ, 2'b00, 2'b00, 1, 0);
    rst = 1;
    cyc("mid_rst", 0, FRZ, 2'b00, 2'b00, 1, 0);
    rst = 0; clr();
    cyc("mid_cleared", 1, DEF, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
